// File: rtl/dram_controller.sv
// dram_controller
// Turns single-word read/write requests into the CSn/RASn/CASn/WEn/A/D command
// sequence of a 32-bit DRAM and returns read data captured from Q. The most
// recently activated row is remembered so that row hits skip the ACT command.
//
// Ports
//   CK, RST                 clock (posedge) and synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE, not in reset)
//   req_write, req_addr     access type and word address {row, col}
//   req_wstrb, req_wdata    byte enables and data for writes
//   rsp_valid, rsp_rdata    one-cycle completion pulse, read data (0 for writes)
//   CSn, RASn, CASn, WEn    registered DRAM command strobes (WEn per byte)
//   A, D                    registered DRAM address and write data
//   Q                       DRAM read data, sampled only on the capture edge
module dram_controller #(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int ADDR_W = 13,
  parameter int TRCD   = 1,
  parameter int CL     = 3
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [3:0]             req_wstrb,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   CSn,
  output logic                   RASn,
  output logic                   CASn,
  output logic [3:0]             WEn,
  output logic [ADDR_W-1:0]      A,
  output logic [31:0]            D,
  input  logic [31:0]            Q
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_RCD,
    S_ACCESS,
    S_RDWAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_open_valid;
  logic [ROW_W-1:0]    r_open_row;

  // Latched request
  logic                r_write;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [3:0]          r_wstrb;
  logic [DATA_W-1:0]   r_wdata;

  // Request fields seen by the next-state logic: live inputs on accept,
  // latched copy otherwise
  logic                w_accept;
  logic                w_write;
  logic [ROW_W-1:0]    w_row;
  logic [COL_W-1:0]    w_col;
  logic [3:0]          w_wstrb;
  logic [DATA_W-1:0]   w_wdata;

  // Registered outputs and their next values
  logic                r_csn, r_rasn, r_casn;
  logic [3:0]          r_wen;
  logic [ADDR_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                w_csn, w_rasn, w_casn;
  logic [3:0]          w_wen;
  logic [ADDR_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_d;
  logic                w_rsp_valid;
  logic [DATA_W-1:0]   w_rsp_rdata;

  assign req_ready = (r_state == S_IDLE) & ~RST;
  assign CSn       = r_csn;
  assign RASn      = r_rasn;
  assign CASn      = r_casn;
  assign WEn       = r_wen;
  assign A         = r_a;
  assign D         = r_d;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_write     = r_write;
    w_row       = r_row;
    w_col       = r_col;
    w_wstrb     = r_wstrb;
    w_wdata     = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_write  = req_write;
          w_row    = req_addr[COL_W +: ROW_W];
          w_col    = req_addr[COL_W-1:0];
          w_wstrb  = req_wstrb;
          w_wdata  = req_wdata;
          if (r_open_valid && (w_row == r_open_row)) w_state_nxt = S_ACCESS;
          else                                         w_state_nxt = S_ACT;
        end
      end
      S_ACT: begin
        if (TRCD > 0) begin
          w_state_nxt = S_RCD;
          w_cnt_nxt   = CNT_W'(TRCD - 1);
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_RCD: begin
        if (r_cnt == '0) w_state_nxt = S_ACCESS;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_ACCESS: begin
        if (r_write) begin
          w_state_nxt = S_IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = '0;
        end else begin
          // Counter hits zero on the edge just before the capture edge
          w_state_nxt = S_RDWAIT;
          w_cnt_nxt   = CNT_W'(CL - 1);
        end
      end
      S_RDWAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = Q;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Command outputs are registered together with the state they belong to,
    // so each state's command is on the pins for exactly that state's cycle.
    w_csn  = 1'b1;
    w_rasn = 1'b1;
    w_casn = 1'b1;
    w_wen  = 4'hF;
    w_a    = r_a;
    w_d    = r_d;
    case (w_state_nxt)
      S_ACT: begin
        w_csn  = 1'b0;
        w_rasn = 1'b0;
        w_a    = ADDR_W'(w_row);
      end
      S_ACCESS: begin
        w_csn  = 1'b0;
        w_rasn = 1'b0;
        w_casn = 1'b0;
        w_a    = ADDR_W'(w_col);
        w_wen  = w_write ? ~w_wstrb : 4'hF;
        w_d    = w_wdata;
      end
      default: ;
    endcase
  end

  // ---- state / command / response registers ----
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_open_valid <= 1'b0;
      r_open_row   <= '0;
      r_csn        <= 1'b1;
      r_rasn       <= 1'b1;
      r_casn       <= 1'b1;
      r_wen        <= 4'hF;
      r_a          <= '0;
      r_d          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_csn       <= w_csn;
      r_rasn      <= w_rasn;
      r_casn      <= w_casn;
      r_wen       <= w_wen;
      r_a         <= w_a;
      r_d         <= w_d;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      if (w_state_nxt == S_ACT) begin
        r_open_valid <= 1'b1;
        r_open_row   <= w_row;
      end
    end
  end

  // ---- request latch (data only, no reset) ----
  always_ff @(posedge CK) begin
    if (w_accept) begin
      r_write <= w_write;
      r_row   <= w_row;
      r_col   <= w_col;
      r_wstrb <= w_wstrb;
      r_wdata <= w_wdata;
    end
  end

endmodule

// File: tb/tb_dram_controller.sv
// Bench for dram_controller: a behavioural DRAM with a CL-deep read pipeline,
// a table of request vectors with expected data/latency/commands, a response
// scoreboard, and hand-written back-to-back, reset and TRCD=0/CL=4 sequences.
module tb_dram_controller;

  localparam int ROW_W = 13, COL_W = 10, ADDR_W = 13;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic RST;
  logic req_valid, req_ready, req_write;
  logic [22:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic CSn, RASn, CASn;
  logic [3:0] WEn;
  logic [ADDR_W-1:0] A;
  logic [31:0] D, Q;

  logic req_valid2, req_ready2, req_write2;
  logic [22:0] req_addr2;
  logic [3:0]  req_wstrb2;
  logic [31:0] req_wdata2;
  logic rsp_valid2;
  logic [31:0] rsp_rdata2;
  logic CSn2, RASn2, CASn2;
  logic [3:0] WEn2;
  logic [ADDR_W-1:0] A2;
  logic [31:0] D2, Q2;

  dram_controller #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W), .TRCD(1), .CL(3)) dut (
    .CK(CK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn), .A(A), .D(D), .Q(Q));

  dram_controller #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W), .TRCD(0), .CL(4)) dut2 (
    .CK(CK), .RST(RST), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2), .req_wstrb(req_wstrb2),
    .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .CSn(CSn2), .RASn(RASn2), .CASn(CASn2), .WEn(WEn2), .A(A2), .D(D2), .Q(Q2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // ---------------- DRAM model for dut (CL=3) ----------------
  logic [31:0] mem [logic [22:0]];
  logic [12:0] m_row = '0;
  logic [22:0] m_key;
  logic [31:0] m_tmp;
  logic [31:0] pd [3];
  logic        pv [3] = '{1'b0, 1'b0, 1'b0};
  int          act_cnt = 0;
  logic [31:0] last_act_a = '0;
  logic [31:0] last_acc_a = '0;
  logic [3:0]  last_acc_wen = 4'h0;

  always @(posedge CK) begin
    pv[0] <= 1'b0;
    if (!CSn && !RASn && CASn) begin
      act_cnt    <= act_cnt + 1;
      last_act_a <= 32'(A);
      m_row      <= A[12:0];
    end
    if (!CSn && !RASn && !CASn) begin
      m_key        = {m_row, A[9:0]};
      m_tmp        = mem.exists(m_key) ? mem[m_key] : 32'h0;
      last_acc_a   <= 32'(A);
      last_acc_wen <= WEn;
      if (&WEn) begin
        pv[0] <= 1'b1;
        pd[0] <= m_tmp;
      end else begin
        for (int i = 0; i < 4; i++) if (!WEn[i]) m_tmp[8*i +: 8] = D[8*i +: 8];
        mem[m_key] = m_tmp;
      end
    end
    pv[1] <= pv[0]; pv[2] <= pv[1];
    pd[1] <= pd[0]; pd[2] <= pd[1];
  end
  assign Q = pv[2] ? pd[2] : 32'hxxxxxxxx;

  // ---------------- DRAM model for dut2 (CL=4), data = f(row,col) ----------------
  logic [12:0] m_row2 = '0;
  logic [31:0] pd2 [4];
  logic        pv2 [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int          act2_cnt = 0, act2_cyc = 0, acc2_cyc = 0;

  always @(posedge CK) begin
    pv2[0] <= 1'b0;
    if (!CSn2 && !RASn2 && CASn2) begin
      act2_cnt <= act2_cnt + 1;
      act2_cyc <= cyc;
      m_row2   <= A2[12:0];
    end
    if (!CSn2 && !RASn2 && !CASn2) begin
      acc2_cyc <= cyc;
      pv2[0]   <= 1'b1;
      pd2[0]   <= {9'h0B4, m_row2, A2[9:0]};
    end
    for (int i = 1; i < 4; i++) begin
      pv2[i] <= pv2[i-1];
      pd2[i] <= pd2[i-1];
    end
  end
  assign Q2 = pv2[3] ? pd2[3] : 32'hxxxxxxxx;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rd;
    int          lat;
    int          t0;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  always @(negedge CK) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got rsp_valid=1 rdata %h want no response", rsp_rdata);
      end else begin
        sb_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, sb_e.rd);
        chk("rsp_latency", 32'(cyc - sb_e.t0), 32'(sb_e.lat));
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input int lat);
    sb_t e;
    e.rd = rd; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
  endtask

  // Drive a request and wait for the accept edge; returns with #1 after it.
  task automatic send(input logic wr, input logic [22:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd, output bit ok);
    int n = 0;
    @(negedge CK);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wstrb = strb; req_wdata = wd;
    while (!req_ready && n < 50) begin @(negedge CK); n++; end
    ok = req_ready;
    if (!ok) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CK); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge CK); n++; end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge CK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {29'd0, CSn, RASn, CASn}, 32'd7);
    chk({tag, "_wen"}, 32'(WEn), 32'hF);
    chk({tag, "_a"}, 32'(A), 32'd0);
    chk({tag, "_d"}, D, 32'd0);
    chk({tag, "_rsp"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [22:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_act;
    logic [12:0] exp_act_a;
    logic [3:0]  exp_wen;
  } vec_t;
  vec_t vt[10];

  initial begin
    bit ok;
    int a0, n, t0;
    logic seen;

    vt[0] = '{1'b1, 23'h000005, 4'hF, 32'hDEADBEEF, 32'h0,        3, 1, 13'h0, 4'h0};
    vt[1] = '{1'b0, 23'h000005, 4'h0, 32'h0,        32'hDEADBEEF, 4, 0, 13'h0, 4'hF};
    vt[2] = '{1'b1, 23'h000005, 4'h5, 32'h11223344, 32'h0,        1, 0, 13'h0, 4'hA};
    vt[3] = '{1'b0, 23'h000005, 4'h0, 32'h0,        32'hDE22BE44, 4, 0, 13'h0, 4'hF};
    vt[4] = '{1'b1, 23'h000400, 4'hF, 32'hA5A5A5A5, 32'h0,        3, 1, 13'h1, 4'h0};
    vt[5] = '{1'b0, 23'h000005, 4'h0, 32'h0,        32'hDE22BE44, 6, 1, 13'h0, 4'hF};
    vt[6] = '{1'b1, 23'h000401, 4'h0, 32'hFFFFFFFF, 32'h0,        3, 1, 13'h1, 4'hF};
    vt[7] = '{1'b0, 23'h000401, 4'h0, 32'h0,        32'h0,        4, 0, 13'h0, 4'hF};
    vt[8] = '{1'b0, 23'h000400, 4'h0, 32'h0,        32'hA5A5A5A5, 4, 0, 13'h0, 4'hF};
    vt[9] = '{1'b1, 23'h000006, 4'hF, 32'h600D600D, 32'h0,        3, 1, 13'h0, 4'h0};

    RST = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wstrb2 = '0; req_wdata2 = '0;
    repeat (3) @(posedge CK);
    #1;
    chk_reset_outputs("reset");
    @(negedge CK);
    RST = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      a0 = act_cnt;
      send(vt[i].wr, vt[i].addr, vt[i].strb, vt[i].wdata, ok);
      if (ok) begin
        push_exp(vt[i].exp_rd, vt[i].exp_lat);
        req_valid = 1'b0;
        wait_idle();
        chk($sformatf("v%0d_act_count", i), 32'(act_cnt - a0), 32'(vt[i].exp_act));
        if (vt[i].exp_act > 0) chk($sformatf("v%0d_act_a", i), last_act_a, 32'(vt[i].exp_act_a));
        chk($sformatf("v%0d_access_a", i), last_acc_a, {22'd0, vt[i].addr[9:0]});
        chk($sformatf("v%0d_access_wen", i), 32'(last_acc_wen), 32'(vt[i].exp_wen));
      end
    end

    // Back-to-back hit reads with req_valid held high
    a0 = act_cnt;
    send(1'b0, 23'h000005, 4'h0, 32'h0, ok);
    if (ok) begin
      push_exp(32'hDE22BE44, 4);
      req_addr = 23'h000006;
      n = 0;
      @(negedge CK);
      while (!req_ready && n < 20) begin @(negedge CK); n++; end
      chk("b2b_accept_on_rsp", {31'd0, rsp_valid}, 32'd1);
      @(posedge CK); #1;
      push_exp(32'h600D600D, 4);
      req_valid = 1'b0;
      wait_idle();
      chk("b2b_no_act", 32'(act_cnt - a0), 32'd0);
    end

    // Reset while a read waits for data
    send(1'b0, 23'h000005, 4'h0, 32'h0, ok);
    req_valid = 1'b0;
    @(posedge CK);
    @(negedge CK);
    RST = 1'b1;
    @(posedge CK); #1;
    sb.delete();
    chk_reset_outputs("midreset");
    @(negedge CK);
    RST = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CK);
      if (rsp_valid) seen = 1'b1;
    end
    chk("midreset_no_rsp", {31'd0, seen}, 32'd0);
    a0 = act_cnt;
    send(1'b0, 23'h000005, 4'h0, 32'h0, ok);
    if (ok) begin
      push_exp(32'hDE22BE44, 6);
      req_valid = 1'b0;
      wait_idle();
      chk("after_reset_act", 32'(act_cnt - a0), 32'd1);
      chk("after_reset_act_a", last_act_a, 32'd0);
    end

    // TRCD=0, CL=4 instance: miss read, row 3 col 3
    a0 = act2_cnt;
    @(negedge CK);
    req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 23'h000C03;
    n = 0;
    while (!req_ready2 && n < 20) begin @(negedge CK); n++; end
    @(posedge CK); #1;
    t0 = cyc;
    req_valid2 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge CK);
      seen = rsp_valid2;
      n++;
    end
    chk("cl4_rsp_seen", {31'd0, seen}, 32'd1);
    chk("cl4_latency", 32'(cyc - t0), 32'd6);
    chk("cl4_rdata", rsp_rdata2, {9'h0B4, 13'd3, 10'd3});
    chk("cl4_act_count", 32'(act2_cnt - a0), 32'd1);
    chk("cl4_act_to_access", 32'(acc2_cyc - act2_cyc), 32'd1);

    repeat (2) @(negedge CK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
